// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register for the 5-stage MIPS core.
// Owns the PC, drives the instruction-memory port and redirects on taken branch/J/JR.
//
// state | meaning
// BOOT  | single idle cycle after reset, no request
// FETCH | request outstanding at PC
// HOLD  | fetched word parked in hold_instr while ID is stalled
// DROP  | finishing a request whose word is squashed, then jump to pend_pc
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic [1:0]  pc_src_i,
  input  logic [31:0] jr_target_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_rdata_i,
  input  logic        imem_ready_i,
  output logic [31:0] ifid_instr_o,
  output logic [31:0] ifid_pc4_o,
  output logic        ifid_valid_o
);

  typedef enum logic [1:0] {S_BOOT, S_FETCH, S_HOLD, S_DROP} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic [31:0] hold_instr_q, hold_instr_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic [31:0] ifid_pc4_q, ifid_pc4_d;
  logic        ifid_valid_q, ifid_valid_d;

  logic [31:0] pc_plus4;
  logic [31:0] target;
  logic        redirect;

  assign pc_plus4 = pc_q + 32'd4;
  assign redirect = ifid_valid_q & (pc_src_i != 2'd0) & ~stall_i;

  always_comb begin
    target = pc_plus4;
    unique case (pc_src_i)
      2'd1:    target = ifid_pc4_q + {{14{ifid_instr_q[15]}}, ifid_instr_q[15:0], 2'b00};
      2'd2:    target = {ifid_pc4_q[31:28], ifid_instr_q[25:0], 2'b00};
      2'd3:    target = {jr_target_i[31:2], 2'b00};
      default: target = pc_plus4;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pend_pc_d    = pend_pc_q;
    hold_instr_d = hold_instr_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pc4_d   = ifid_pc4_q;
    ifid_valid_d = ifid_valid_q;

    // Any unstalled cycle that does not load an instruction below inserts a bubble.
    if (!stall_i) begin
      ifid_valid_d = 1'b0;
      ifid_instr_d = 32'h0;
    end

    unique case (state_q)
      S_BOOT: state_d = S_FETCH;
      S_FETCH: begin
        if (redirect) begin
          if (imem_ready_i) begin
            pc_d = target;
          end else begin
            pend_pc_d = target;
            state_d   = S_DROP;
          end
        end else if (imem_ready_i) begin
          if (!stall_i) begin
            ifid_instr_d = imem_rdata_i;
            ifid_pc4_d   = pc_plus4;
            ifid_valid_d = 1'b1;
            pc_d         = pc_plus4;
          end else begin
            hold_instr_d = imem_rdata_i;
            state_d      = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (!stall_i) begin
          state_d = S_FETCH;
          if (redirect) begin
            pc_d = target;
          end else begin
            ifid_instr_d = hold_instr_q;
            ifid_pc4_d   = pc_plus4;
            ifid_valid_d = 1'b1;
            pc_d         = pc_plus4;
          end
        end
      end
      S_DROP: begin
        if (imem_ready_i) begin
          pc_d    = pend_pc_q;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_BOOT;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_BOOT;
      pc_q         <= RESET_PC;
      pend_pc_q    <= 32'h0;
      hold_instr_q <= 32'h0;
      ifid_instr_q <= 32'h0;
      ifid_pc4_q   <= 32'h0;
      ifid_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pend_pc_q    <= pend_pc_d;
      hold_instr_q <= hold_instr_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc4_q   <= ifid_pc4_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

  assign imem_req_o   = (state_q == S_FETCH) || (state_q == S_DROP);
  assign imem_addr_o  = pc_q;
  assign ifid_instr_o = ifid_instr_q;
  assign ifid_pc4_o   = ifid_pc4_q;
  assign ifid_valid_o = ifid_valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: hand-derived per-cycle vector table for the corner cases,
// then a randomized wait/stall run checked against an in-order instruction queue.
module tb_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst, stall, imem_ready;
  logic [1:0]  pc_src;
  logic [31:0] jr_target, imem_rdata;
  logic        imem_req, ifid_valid;
  logic [31:0] imem_addr, ifid_instr, ifid_pc4;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(RST_PC)) dut (
    .clk_i(clk), .rst_i(rst), .stall_i(stall), .pc_src_i(pc_src),
    .jr_target_i(jr_target), .imem_req_o(imem_req), .imem_addr_o(imem_addr),
    .imem_rdata_i(imem_rdata), .imem_ready_i(imem_ready),
    .ifid_instr_o(ifid_instr), .ifid_pc4_o(ifid_pc4), .ifid_valid_o(ifid_valid)
  );

  typedef struct {
    logic        rst;
    logic        stall;
    logic [1:0]  pcsrc;
    logic [31:0] jrt;
    logic        ready;
    logic [31:0] rdata;
    logic        ereq;
    logic [31:0] eaddr;
    logic        evalid;
    logic [31:0] einstr;
    logic [31:0] epc4;
  } vec_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc4;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  function automatic vec_t mk(input logic r, input logic s, input logic [1:0] p,
                              input logic [31:0] j, input logic rd, input logic [31:0] d,
                              input logic eq, input logic [31:0] ea, input logic ev,
                              input logic [31:0] ei, input logic [31:0] ep);
    vec_t v;
    v.rst = r; v.stall = s; v.pcsrc = p; v.jrt = j; v.ready = rd; v.rdata = d;
    v.ereq = eq; v.eaddr = ea; v.evalid = ev; v.einstr = ei; v.epc4 = ep;
    return v;
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC3C3_0000;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

  initial begin
    logic [31:0] last_pc4, prev_addr;
    logic        prev_req, prev_ready;
    int          delivered;
    exp_t        e;

    rst = 1'b1; stall = 1'b0; pc_src = 2'd0; jr_target = 32'h0;
    imem_ready = 1'b0; imem_rdata = JUNK;

    //              rst stl pc  jrt           rdy rdata          req addr           v  instr          pc4
    vecs.push_back(mk(0, 0, 0, 32'h0,        1, JUNK,          0, 32'h0000_0100, 0, 32'h0,        32'h0));        // BOOT
    vecs.push_back(mk(0, 0, 0, 32'h0,        1, 32'h2000_0100, 1, 32'h0000_0100, 0, 32'h0,        32'h0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        1, 32'h2000_0104, 1, 32'h0000_0104, 1, 32'h2000_0100, 32'h0000_0104));
    vecs.push_back(mk(0, 0, 0, 32'h0,        1, 32'h2000_0108, 1, 32'h0000_0108, 1, 32'h2000_0104, 32'h0000_0108));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, JUNK,          1, 32'h0000_010C, 1, 32'h2000_0108, 32'h0000_010C)); // wait states
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, JUNK,          1, 32'h0000_010C, 0, 32'h0,        32'h0000_010C));
    vecs.push_back(mk(0, 0, 0, 32'h0,        1, 32'h2000_010C, 1, 32'h0000_010C, 0, 32'h0,        32'h0000_010C));
    vecs.push_back(mk(0, 1, 0, 32'h0,        1, 32'h2402_0005, 1, 32'h0000_0110, 1, 32'h2000_010C, 32'h0000_0110)); // stall hit
    vecs.push_back(mk(0, 1, 0, 32'h0,        0, JUNK,          0, 32'h0000_0110, 1, 32'h2000_010C, 32'h0000_0110));
    vecs.push_back(mk(0, 1, 0, 32'h0,        0, JUNK,          0, 32'h0000_0110, 1, 32'h2000_010C, 32'h0000_0110));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, JUNK,          0, 32'h0000_0110, 1, 32'h2000_010C, 32'h0000_0110));
    vecs.push_back(mk(0, 0, 0, 32'h0,        1, 32'h1000_0003, 1, 32'h0000_0114, 1, 32'h2402_0005, 32'h0000_0114));
    vecs.push_back(mk(0, 0, 1, 32'h0,        1, 32'h2000_0118, 1, 32'h0000_0118, 1, 32'h1000_0003, 32'h0000_0118)); // taken BEQ
    vecs.push_back(mk(0, 0, 1, 32'h0,        1, 32'h2000_0124, 1, 32'h0000_0124, 0, 32'h0,        32'h0000_0118));
    vecs.push_back(mk(0, 0, 3, 32'h0000_1003, 0, JUNK,         1, 32'h0000_0128, 1, 32'h2000_0124, 32'h0000_0128)); // JR in wait
    vecs.push_back(mk(0, 0, 3, 32'h0000_1003, 0, JUNK,         1, 32'h0000_0128, 0, 32'h0,        32'h0000_0128));
    vecs.push_back(mk(0, 0, 0, 32'h0,        1, 32'h2000_0128, 1, 32'h0000_0128, 0, 32'h0,        32'h0000_0128));
    vecs.push_back(mk(0, 0, 0, 32'h0,        1, 32'h2000_1000, 1, 32'h0000_1000, 0, 32'h0,        32'h0000_0128));
    vecs.push_back(mk(0, 0, 3, 32'h0000_2000, 0, JUNK,         1, 32'h0000_1004, 1, 32'h2000_1000, 32'h0000_1004));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, JUNK,          1, 32'h0000_1004, 0, 32'h0,        32'h0000_1004));
    vecs.push_back(mk(1, 0, 0, 32'h0,        0, JUNK,          1, 32'h0000_1004, 0, 32'h0,        32'h0000_1004)); // reset in DROP
    vecs.push_back(mk(0, 0, 0, 32'h0,        1, JUNK,          0, 32'h0000_0100, 0, 32'h0,        32'h0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        1, 32'h2000_0100, 1, 32'h0000_0100, 0, 32'h0,        32'h0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        1, 32'h0800_0050, 1, 32'h0000_0104, 1, 32'h2000_0100, 32'h0000_0104));
    vecs.push_back(mk(0, 0, 2, 32'h0,        1, JUNK,          1, 32'h0000_0108, 1, 32'h0800_0050, 32'h0000_0108)); // J
    vecs.push_back(mk(0, 0, 2, 32'h0,        1, 32'h2000_0140, 1, 32'h0000_0140, 0, 32'h0,        32'h0000_0108));
    vecs.push_back(mk(0, 1, 0, 32'h0,        1, 32'h2000_0144, 1, 32'h0000_0144, 1, 32'h2000_0140, 32'h0000_0144));
    vecs.push_back(mk(0, 0, 3, 32'h0000_0207, 0, JUNK,         0, 32'h0000_0144, 1, 32'h2000_0140, 32'h0000_0144)); // redirect out of HOLD
    vecs.push_back(mk(0, 0, 0, 32'h0,        1, 32'h1000_FFFE, 1, 32'h0000_0204, 0, 32'h0,        32'h0000_0144));
    vecs.push_back(mk(0, 0, 1, 32'h0,        0, JUNK,          1, 32'h0000_0208, 1, 32'h1000_FFFE, 32'h0000_0208)); // backward branch
    vecs.push_back(mk(0, 1, 0, 32'h0,        1, JUNK,          1, 32'h0000_0208, 0, 32'h0,        32'h0000_0208));
    vecs.push_back(mk(0, 0, 0, 32'h0,        1, 32'h2000_0200, 1, 32'h0000_0200, 0, 32'h0,        32'h0000_0208));
    vecs.push_back(mk(0, 0, 3, 32'hFFFF_FFFF, 0, JUNK,         1, 32'h0000_0204, 1, 32'h2000_0200, 32'h0000_0204));
    vecs.push_back(mk(0, 0, 0, 32'h0,        1, JUNK,          1, 32'h0000_0204, 0, 32'h0,        32'h0000_0204));
    vecs.push_back(mk(0, 0, 0, 32'h0,        1, 32'hAAAA_0001, 1, 32'hFFFF_FFFC, 0, 32'h0,        32'h0000_0204)); // PC wrap
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, JUNK,          1, 32'h0000_0000, 1, 32'hAAAA_0001, 32'h0000_0000));

    repeat (2) @(posedge clk);

    foreach (vecs[i]) begin
      @(negedge clk);
      chk("imem_req",   i, {31'h0, imem_req},   {31'h0, vecs[i].ereq});
      chk("imem_addr",  i, imem_addr,           vecs[i].eaddr);
      chk("ifid_valid", i, {31'h0, ifid_valid}, {31'h0, vecs[i].evalid});
      chk("ifid_instr", i, ifid_instr,          vecs[i].einstr);
      chk("ifid_pc4",   i, ifid_pc4,            vecs[i].epc4);
      rst = vecs[i].rst; stall = vecs[i].stall; pc_src = vecs[i].pcsrc;
      jr_target = vecs[i].jrt; imem_ready = vecs[i].ready; imem_rdata = vecs[i].rdata;
    end

    // Random wait states and stalls, straight-line code: every word must arrive once, in order.
    @(negedge clk);
    rst = 1'b1; stall = 1'b0; pc_src = 2'd0; imem_ready = 1'b0; imem_rdata = JUNK;
    repeat (2) @(posedge clk);
    for (int k = 0; k < 400; k++) begin
      e.instr = mem_word(RST_PC + 32'(4 * k));
      e.pc4   = RST_PC + 32'(4 * k + 4);
      sb.push_back(e);
    end
    last_pc4 = 32'h0; prev_req = 1'b0; prev_ready = 1'b0; prev_addr = 32'h0; delivered = 0;

    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (prev_req && !prev_ready && imem_req)
        chk("addr_stable", c, imem_addr, prev_addr);
      if (ifid_valid && ifid_pc4 != last_pc4) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", c, ifid_pc4, 32'h0);
        end else begin
          e = sb.pop_front();
          chk("sb_instr", c, ifid_instr, e.instr);
          chk("sb_pc4",   c, ifid_pc4,   e.pc4);
        end
        last_pc4 = ifid_pc4;
        delivered++;
      end
      rst        = 1'b0;
      stall      = ($urandom_range(0, 3) == 0);
      imem_ready = ($urandom_range(0, 9) < 6);
      imem_rdata = imem_ready ? mem_word(imem_addr) : JUNK;
      prev_req   = imem_req;
      prev_ready = imem_ready;
      prev_addr  = imem_addr;
    end

    checks++;
    if (delivered < 50) begin
      failures++;
      $display("FAIL sb_progress: delivered %0d instructions, required at least 50", delivered);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage and IF/ID pipeline register of the 5-stage MIPS core, directly upstream of the ID-stage decoder. It owns the PC, issues requests on the instruction-memory port and presents fetched instructions to ID. It consumes the decoder's `PCSrc` to redirect fetch on taken branches, `J` and `JR`. There is no delay slot: the instruction behind a taken redirect is squashed.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `stall`  in  1  hazard-unit hold; freezes PC and IF/ID.
- `PCSrc`  in  2  from decoder for the instruction in ID: 0 = +4, 1 = Branch, 2 = J, 3 = JR.
- `JRTarget`  in  32  rs value for JR, already forwarded in ID.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  32  fetch address, equal to PC.
- `imem_rdata`  in  32  instruction word; valid only in a cycle where `imem_ready`=1.
- `imem_ready`  in  1  request completes this cycle.
- `IFID_Instr`  out  32  instruction to ID; 0 (NOP) when bubble.
- `IFID_PC4`  out  32  fetch address + 4 of `IFID_Instr`.
- `IFID_Valid`  out  1  IF/ID holds a real instruction.

## Operation
- **State machine:** BOOT, FETCH, HOLD, DROP.
- **redirect** = `IFID_Valid` & (`PCSrc`≠0) & ~`stall`.
- **Targets (mod 2^32):**
  - Branch: `IFID_PC4` + (sext(`IFID_Instr`[15:0]) << 2).
  - J: {`IFID_PC4`[31:28], `IFID_Instr`[25:0], 2'b00}.
  - JR: {`JRTarget`[31:2], 2'b00}.
- **Request protocol:** `imem_req`=1 exactly in FETCH and DROP. `imem_addr`=PC and is held stable from request start until `imem_ready`.
- **IF/ID update rule.** Each cycle with `stall`=0, IF/ID loads either a new instruction or a bubble. A bubble is Valid=0, Instr=0, PC4 unchanged. With `stall`=1, IF/ID holds.
- **BOOT:** req=0; next state FETCH. Entered only from reset.
- **FETCH:**
  - redirect & ready: discard rdata; PC←target; IF/ID bubble; stay in FETCH.
  - redirect & ~ready: latch target into `pend_pc`; IF/ID bubble; go to DROP.
  - ready & ~stall: IF/ID ← {rdata, PC+4, 1}; PC←PC+4.
  - ready & stall: rdata → skid buffer `hold_instr`; go to HOLD; PC unchanged.
  - ~ready & ~stall: IF/ID bubble.
- **HOLD:**
  - req=0.
  - stall: stay in HOLD.
  - ~stall & redirect: discard buffer; PC←target; IF/ID bubble; go to FETCH.
  - ~stall & ~redirect: IF/ID ← {`hold_instr`, PC+4, 1}; PC←PC+4; go to FETCH.
- **DROP:**
  - req=1 at the old address.
  - When ready: discard rdata; PC←`pend_pc`; go to FETCH.
  - IF/ID keeps bubbling while ~stall.
  - A new redirect cannot occur here because IF/ID is invalid.
- **Adder width:** PC+4 wraps at 2^32 without a flag.

## Timing
- **Reset values:**
  - PC = `RESET_PC`; state BOOT.
  - `imem_req`=0; `imem_addr`=`RESET_PC`.
  - `IFID_Instr`=0; `IFID_PC4`=0; `IFID_Valid`=0.
  - `pend_pc`=0; `hold_instr`=0.
- **Reset mid-operation:** `rst` overrides all other inputs on its edge and any in-flight request is abandoned. The memory must tolerate `imem_req` dropping without ready.
- **First request:** starts the cycle after `rst` deasserts. This is BOOT's single cycle.
- **Latency:**
  - Zero-wait memory gives 1 instruction per cycle.
  - `imem_ready` in cycle N puts the instruction in IF/ID from cycle N+1.
- **Redirect penalty** (zero-wait memory): redirect decided in cycle N → fetch from the target in N+1 → target instruction valid in IF/ID at N+2. Exactly one bubble.
- **Simultaneous stall & ready in FETCH:** the word is never lost; it is delivered from HOLD on the first cycle with `stall`=0.
- **Inputs:** `PCSrc` and `JRTarget` are sampled only when `IFID_Valid`=1; otherwise ignored.

## Test plan
- **Sequential fetch:** `imem_ready`=1 always, `RESET_PC`=0x100 → addresses 0x100, 0x104, 0x108 on consecutive cycles; `IFID_PC4`=0x104, 0x108, ….
- **Wait states:** `imem_ready` low for 2 cycles at 0x104 → `imem_addr` held at 0x104 for 3 cycles; 2 bubbles in IF/ID; no address skipped.
- **Stall hit:** `stall`=1 for 3 cycles starting with the cycle `imem_ready`=1 delivers 0x2402_0005 → HOLD, req=0. The word appears in IF/ID the cycle after stall drops; the next fetch is PC+4.
- **Taken BEQ:** IF/ID = 0x1000_0003 at `IFID_PC4`=0x204 with `PCSrc`=1 → next `imem_addr`=0x210; the word fetched at 0x204 is discarded; one bubble.
- **JR during wait:** `PCSrc`=3, `JRTarget`=0x0000_1003, `imem_ready`=0 for 2 cycles → DROP; address held; then fetch at 0x1000; the late word is discarded.
- **Reset in DROP:** assert `rst` → next cycle `imem_req`=0, PC=`RESET_PC`, `IFID_Valid`=0, state BOOT.
